mem_port_arbiter: RTL

- Shares one cache-line memory port between the instruction-fetch requester (port 0, read-only) and the data-cache DMA requester (port 1, read/write).
- Sits between both L1 controllers and the memory/bus bridge.
- Uses the same req/addrOK/dataOK protocol on every side.
- Serializes transactions, one outstanding at a time, and routes handshakes and read data back to the granted requester.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one cache-line memory port: port 0 = I-fetch (read-only), port 1 = D-cache DMA (read/write).
// Optional build macro ARB_ROUND_ROBIN_EN replaces fixed priority with a last-served round-robin pointer.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter  int OFFSET_W    = 2,
  parameter  int PRIO_DCACHE = 1,
  localparam int LINE_W      = 32 * (2 << OFFSET_W)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  output logic              m0_addrOK,
  output logic              m0_dataOK,
  output logic [LINE_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [1:0]        m1_size,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_addrOK,
  output logic              m1_dataOK,
  output logic [LINE_W-1:0] m1_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_addrOK,
  input  logic              mem_dataOK,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              arb_busy,
  output logic              arb_grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   pick;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // On a collision the port that was not served last wins.
  assign pick = ~rr_q;
`else
  assign pick = (PRIO_DCACHE != 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          grant_d = pick;
          state_d = ADDR;
        end else if (m0_req) begin
          grant_d = 1'b0;
          state_d = ADDR;
        end else if (m1_req) begin
          grant_d = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // Writes finish at address acceptance; reads wait for the line.
        if (mem_addrOK) begin
          state_d = mem_wr ? IDLE : DATA;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d    = grant_q;
`endif
        end
      end
      DATA: begin
        if (mem_dataOK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    mem_wstrb = '0;
    m0_addrOK = 1'b0;
    m1_addrOK = 1'b0;
    m0_dataOK = 1'b0;
    m1_dataOK = 1'b0;
    if (state_q == ADDR) begin
      mem_req = 1'b1;
      if (grant_q) begin
        mem_wr    = m1_wr;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_size  = m1_size;
        mem_wstrb = m1_wstrb;
        m1_addrOK = mem_addrOK;
      end else begin
        // Instruction fetch is always a full-word read.
        mem_addr  = m0_addr;
        mem_size  = 2'd2;
        mem_wstrb = 4'b1111;
        m0_addrOK = mem_addrOK;
      end
    end
    if (state_q == DATA) begin
      if (grant_q) m1_dataOK = mem_dataOK;
      else         m0_dataOK = mem_dataOK;
    end
  end

  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign arb_busy  = (state_q != IDLE);
  assign arb_grant = grant_q;

endmodule
